// File: rtl/frame_writer.sv
// Packs a raster stream of 8-bit palette indices into 128-bit words and writes one frame
// into the SDRAM back buffer. Build macro TRANSPARENT_KEY_EN enables per-pixel byte enables.
module frame_writer #(
  parameter int unsigned H_PIX = 640,
  parameter int unsigned V_PIX = 480,
  parameter logic [21:0] ADDR1 = 22'h100000,
  parameter logic [21:0] ADDR2 = 22'h200000,
  parameter logic [7:0]  KEY   = 8'h00
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         frame_start_i,
  input  logic         frame_flip_i,
  input  logic         rd_busy_i,
  input  logic [7:0]   pix_data_i,
  input  logic         pix_valid_i,
  output logic         pix_ready_o,
  output logic [21:0]  sdram_addr_o,
  output logic [127:0] sdram_data_o,
  output logic [15:0]  sdram_be_o,
  output logic         sdram_wr_o,
  input  logic         sdram_ac_i,
  output logic         active_o,
  output logic         frame_done_o
);
  localparam logic [14:0] WORDS = 15'((H_PIX / 16) * V_PIX);
`ifdef TRANSPARENT_KEY_EN
  localparam logic KEY_EN = 1'b1;
`else
  localparam logic KEY_EN = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_q, state_d;
  logic [21:0]  base_q, base_d;
  logic [3:0]   pack_cnt_q, pack_cnt_d;
  logic [127:0] pack_q, pack_d, hold_q, hold_d;
  logic [15:0]  pack_be_q, pack_be_d, hold_be_q, hold_be_d;
  logic         hold_valid_q, hold_valid_d;
  logic [14:0]  word_idx_q, word_idx_d;
  logic [14:0]  packed_q, packed_d;
  logic         done_q, done_d;
  logic         all_taken, accept, pix_be, skip, retire;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    pack_cnt_d   = pack_cnt_q;
    pack_d       = pack_q;
    pack_be_d    = pack_be_q;
    hold_d       = hold_q;
    hold_be_d    = hold_be_q;
    hold_valid_d = hold_valid_q;
    word_idx_d   = word_idx_q;
    packed_d     = packed_q;
    done_d       = 1'b0;

    all_taken   = (packed_q == WORDS);
    pix_ready_o = (state_q == RUN) & ~((pack_cnt_q == 4'd15) & hold_valid_q) & ~all_taken;
    accept      = pix_valid_i & pix_ready_o;
    // Without the key feature every byte is enabled.
    pix_be      = ~KEY_EN | (pix_data_i != KEY);
    // A fully transparent word retires on its own, without touching the SDRAM.
    skip        = (state_q == RUN) & KEY_EN & hold_valid_q & (hold_be_q == 16'h0000);
    sdram_wr_o  = (state_q == RUN) & hold_valid_q & ~skip & ~rd_busy_i;
    retire      = (sdram_wr_o & sdram_ac_i) | skip;

    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          base_d       = frame_flip_i ? ADDR2 : ADDR1;
          pack_cnt_d   = 4'd0;
          hold_valid_d = 1'b0;
          word_idx_d   = 15'd0;
          packed_d     = 15'd0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (retire) begin
          hold_valid_d = 1'b0;
          word_idx_d   = word_idx_q + 15'd1;
          if (word_idx_q == WORDS - 15'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        if (accept) begin
          pack_d[{pack_cnt_q, 3'b000} +: 8] = pix_data_i;
          pack_be_d[pack_cnt_q]             = pix_be;
          pack_cnt_d                        = pack_cnt_q + 4'd1;
          if (pack_cnt_q == 4'd15) begin
            hold_d       = pack_d;
            hold_be_d    = pack_be_d;
            hold_valid_d = 1'b1;
            packed_d     = packed_q + 15'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= 22'd0;
      pack_cnt_q   <= 4'd0;
      pack_q       <= 128'd0;
      pack_be_q    <= 16'd0;
      hold_q       <= 128'd0;
      hold_be_q    <= 16'd0;
      hold_valid_q <= 1'b0;
      word_idx_q   <= 15'd0;
      packed_q     <= 15'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      pack_cnt_q   <= pack_cnt_d;
      pack_q       <= pack_d;
      pack_be_q    <= pack_be_d;
      hold_q       <= hold_d;
      hold_be_q    <= hold_be_d;
      hold_valid_q <= hold_valid_d;
      word_idx_q   <= word_idx_d;
      packed_q     <= packed_d;
      done_q       <= done_d;
    end
  end

  assign sdram_addr_o = base_q + {7'd0, word_idx_q};
  assign sdram_data_o = hold_q;
  assign sdram_be_o   = hold_valid_q ? hold_be_q : 16'h0000;
  assign active_o     = (state_q == RUN);
  assign frame_done_o = done_q;

endmodule
